// File: rtl/ecc_pkg.sv
// Shared sect163r2 constants and the ECDH sequencer state type.
package ecc_pkg;

  localparam int NUM_BITS = 163;

  // sect163r2 base point G
  localparam logic [NUM_BITS:0] GX = 164'h3f0eba16286a2d57ea0991168d4994637e8343e36;
  localparam logic [NUM_BITS:0] GY = 164'h0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1;

  typedef enum logic [2:0] {
    IDLE,
    PUB_START,
    PUB_WAIT,
    SES_START,
    SES_WAIT
  } ecdh_state_t;

endpackage

// File: rtl/pm_timeout_counter.sv
// Watchdog for one point_multiplication run; expire is high on the last allowed wait cycle.
module pm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  assign expire = (count == CW'(TIMEOUT_CYCLES - 1));

  // Saturates at the limit so a lingering enable never wraps back to zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ecdh_sequencer.sv
// Drives point_multiplication through the two ECDH steps (k*G, then k*peer)
// and holds each result for the downstream key-load logic.
module ecdh_sequencer
  import ecc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_BITS:0] priv_key,
  input  logic [NUM_BITS:0] peer_x,
  input  logic [NUM_BITS:0] peer_y,
  input  logic              gen_pub,
  input  logic              gen_ses,
  output logic [NUM_BITS:0] pub_x,
  output logic [NUM_BITS:0] pub_y,
  output logic [NUM_BITS:0] ses_x,
  output logic [NUM_BITS:0] ses_y,
  output logic              pub_valid,
  output logic              ses_valid,
  output logic              busy,
  output logic              err,
  output logic              pm_start,
  output logic [NUM_BITS:0] pm_k,
  output logic [NUM_BITS:0] pm_x,
  output logic [NUM_BITS:0] pm_y,
  input  logic [NUM_BITS:0] pm_skx,
  input  logic [NUM_BITS:0] pm_sky,
  input  logic              pm_done
);

  ecdh_state_t state, next_state;

  logic [NUM_BITS:0] priv_q;
  logic              key_loaded;
  logic              done_q;
  logic              done_rise;
  logic              expire;

  logic accept_pub, accept_ses, reject;
  logic complete_pub, complete_ses, timeout;
  logic cnt_clear, cnt_enable;

  assign done_rise = pm_done & ~done_q;
  assign busy      = (state != IDLE);
  assign pm_start  = (state == PUB_START) || (state == SES_START);

  pm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    accept_pub   = 1'b0;
    accept_ses   = 1'b0;
    reject       = 1'b0;
    complete_pub = 1'b0;
    complete_ses = 1'b0;
    timeout      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;
    unique case (state)
      IDLE: begin
        // gen_pub has priority; a simultaneous gen_ses is dropped without err
        if (gen_pub) begin
          accept_pub = 1'b1;
          next_state = PUB_START;
        end else if (gen_ses) begin
          if (!key_loaded || (peer_x == '0 && peer_y == '0)) begin
            reject = 1'b1;
          end else begin
            accept_ses = 1'b1;
            next_state = SES_START;
          end
        end
      end
      PUB_START: begin
        cnt_clear  = 1'b1;
        next_state = PUB_WAIT;
      end
      SES_START: begin
        cnt_clear  = 1'b1;
        next_state = SES_WAIT;
      end
      PUB_WAIT: begin
        cnt_enable = 1'b1;
        if (done_rise) begin
          complete_pub = 1'b1;
          next_state   = IDLE;
        end else if (expire) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      SES_WAIT: begin
        cnt_enable = 1'b1;
        if (done_rise) begin
          complete_ses = 1'b1;
          next_state   = IDLE;
        end else if (expire) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are loaded on acceptance so they are stable from START through WAIT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      priv_q     <= '0;
      key_loaded <= 1'b0;
      done_q     <= 1'b0;
      err        <= 1'b0;
      pm_k       <= '0;
      pm_x       <= '0;
      pm_y       <= '0;
      pub_x      <= '0;
      pub_y      <= '0;
      ses_x      <= '0;
      ses_y      <= '0;
      pub_valid  <= 1'b0;
      ses_valid  <= 1'b0;
    end else begin
      done_q <= pm_done;
      err    <= reject | timeout;
      if (accept_pub) begin
        priv_q     <= priv_key;
        key_loaded <= 1'b1;
        pm_k       <= priv_key;
        pm_x       <= GX;
        pm_y       <= GY;
        pub_valid  <= 1'b0;
        ses_valid  <= 1'b0;
      end
      if (accept_ses) begin
        pm_k      <= priv_q;
        pm_x      <= peer_x;
        pm_y      <= peer_y;
        ses_valid <= 1'b0;
      end
      if (complete_pub) begin
        pub_x     <= pm_skx;
        pub_y     <= pm_sky;
        pub_valid <= 1'b1;
      end
      if (complete_ses) begin
        ses_x     <= pm_skx;
        ses_y     <= pm_sky;
        ses_valid <= 1'b1;
      end
    end
  end

endmodule
